video_timing_generator: RTL
===========================

Name: video_timing_generator

Overview:
- Parametrised raster timing generator; drives hsync/vsync/blank and pixel position for the video output path.
- Generalises the fixed 640x480 sync generator with:
  - configurable counter width and sync polarity
  - a pixel clock-enable, so it can run off a faster system clock
  - line/frame start strobes and a frame counter
  - a second position counter running FETCH_LEAD pixels ahead, so pixel sources with memory latency can issue reads early.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_RIGHT_BORDER, 8, border pixels after active
- H_FRONT_PORCH, 8, pixels from end of border to hsync
- H_SYNC_TIME, 96, hsync width in pixels
- H_BACK_PORCH, 40, pixels after hsync
- H_LEFT_BORDER, 8, border pixels before next active
- V_VISIBLE, 480, active lines
- V_BOTTOM_BORDER, 8, border lines after active
- V_FRONT_PORCH, 2, lines before vsync
- V_SYNC_TIME, 2, vsync width in lines
- V_BACK_PORCH, 25, lines after vsync
- V_TOP_BORDER, 8, border lines before next active
- H_SYNC_POL, 0, 1 = hsync active-high, 0 = active-low
- V_SYNC_POL, 0, 1 = vsync active-high, 0 = active-low
- COUNT_W, 10, width of position counters
- FRAME_W, 8, width of frame counter
- FETCH_LEAD, 2, pixel ticks by which fetch position leads display position (0..H_TOTAL-1)

Derived values:
- H_SYNC_START = H_VISIBLE + H_RIGHT_BORDER + H_FRONT_PORCH; H_SYNC_END = H_SYNC_START + H_SYNC_TIME; H_TOTAL = H_SYNC_END + H_BACK_PORCH + H_LEFT_BORDER.
- V_* derived identically.
- Defaults give H_TOTAL = 800, H_SYNC = [656,752), V_TOTAL = 525, V_SYNC = [490,492).
- Elaboration error if H_TOTAL or V_TOTAL > 2^COUNT_W, or FETCH_LEAD >= H_TOTAL.

Ports:
- i_clk  in  1  system/pixel clock
- i_rst  in  1  reset; synchronous, active-high
- i_ce  in  1  pixel-tick enable; tie to 1 for one pixel per clock
- o_hsync  out  1  registered hsync, polarity per H_SYNC_POL
- o_vsync  out  1  registered vsync, polarity per V_SYNC_POL
- o_hblank  out  1  hpos >= H_VISIBLE
- o_vblank  out  1  vpos >= V_VISIBLE
- o_visible  out  1  ~hblank & ~vblank
- o_hpos  out  COUNT_W  display x
- o_vpos  out  COUNT_W  display y
- o_line_start  out  1  strobe: i_ce & (hpos == 0)
- o_frame_start  out  1  strobe: i_ce & (hpos == 0) & (vpos == 0)
- o_frame_count  out  FRAME_W  completed-frame counter
- o_fetch_hpos  out  COUNT_W  fetch x, FETCH_LEAD ticks ahead
- o_fetch_vpos  out  COUNT_W  fetch y
- o_fetch_visible  out  1  fetch position inside active area

Behaviour:
- Reset (i_rst high at a clock edge; overrides i_ce):
  - hpos = vpos = 0, frame_count = 0
  - o_hsync and o_vsync at inactive level
  - fetch position = (FETCH_LEAD, 0)
  - Mid-frame reset restarts the frame on the next clock, with no partial sync pulse extension.
- All state advances only on clocks where i_ce = 1. With i_ce = 0 every output holds, and both strobes are 0.
- Display counter:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos advances.
  - vpos wraps at V_TOTAL-1 to 0.
  - frame_count increments (mod 2^FRAME_W) on the tick that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Fetch counter:
  - Identical wrap rules, independent registers.
  - Stays exactly FETCH_LEAD ticks ahead, including across line and frame wraps.
  - FETCH_LEAD = 0 makes fetch position equal display position.
- Sync timing:
  - o_hsync is registered, and active exactly on clocks where o_hpos is in [H_SYNC_START, H_SYNC_END): it is computed from the next-position value.
  - o_vsync is active exactly while o_vpos is in [V_SYNC_START, V_SYNC_END); it changes only together with o_vpos.
- Blank, visible and strobe outputs are combinational from the registered positions (and i_ce for the strobes); no added latency.
- Latency: zero between o_hpos/o_vpos and all display outputs.

Test Plan:
- Defaults, i_ce = 1, run 2 frames:
  - hsync low exactly for hpos 656..751
  - vsync low exactly for vpos 490..491
  - H_TOTAL 800, V_TOTAL 525
  - frame_count 0 -> 1 -> 2
  - o_frame_start pulses every 420000 clocks.
- i_ce toggling 1,0,1,0: positions advance every other clock; strobes only on ce-high clocks; outputs stable on ce-low.
- FETCH_LEAD = 2:
  - at display (798,524) fetch = (0,0)
  - at display (0,0) fetch = (2,0)
  - o_fetch_visible rises 2 ticks before o_visible.
- H_SYNC_POL = V_SYNC_POL = 1, small timing (H 8/1/1/2/1/1, V 4/1/1/1/1/1): hsync high hpos 10..11, H_TOTAL 14; vsync high vpos 6, V_TOTAL 9.
- Assert i_rst at (300,200): next clock hpos = vpos = 0, syncs inactive, frame_count = 0, fetch = (FETCH_LEAD, 0).
- FRAME_W = 2, run 5 frames: frame_count 0,1,2,3,0,1.

Source files
------------

// File: rtl/video_timing_generator.sv
// Raster timing generator: display and fetch position counters, registered
// hsync/vsync, blanking, line/frame strobes and a completed-frame counter.
// All state advances only on pixel ticks (i_ce = 1).
module video_timing_generator #(
    parameter int H_VISIBLE       = 640,
    parameter int H_RIGHT_BORDER  = 8,
    parameter int H_FRONT_PORCH   = 8,
    parameter int H_SYNC_TIME     = 96,
    parameter int H_BACK_PORCH    = 40,
    parameter int H_LEFT_BORDER   = 8,
    parameter int V_VISIBLE       = 480,
    parameter int V_BOTTOM_BORDER = 8,
    parameter int V_FRONT_PORCH   = 2,
    parameter int V_SYNC_TIME     = 2,
    parameter int V_BACK_PORCH    = 25,
    parameter int V_TOP_BORDER    = 8,
    parameter int H_SYNC_POL      = 0,
    parameter int V_SYNC_POL      = 0,
    parameter int COUNT_W         = 10,
    parameter int FRAME_W         = 8,
    parameter int FETCH_LEAD      = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ce,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_hblank,
    output logic               o_vblank,
    output logic               o_visible,
    output logic [COUNT_W-1:0] o_hpos,
    output logic [COUNT_W-1:0] o_vpos,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [FRAME_W-1:0] o_frame_count,
    output logic [COUNT_W-1:0] o_fetch_hpos,
    output logic [COUNT_W-1:0] o_fetch_vpos,
    output logic               o_fetch_visible
);

    localparam int H_SYNC_START = H_VISIBLE + H_RIGHT_BORDER + H_FRONT_PORCH;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_TIME;
    localparam int H_TOTAL      = H_SYNC_END + H_BACK_PORCH + H_LEFT_BORDER;
    localparam int V_SYNC_START = V_VISIBLE + V_BOTTOM_BORDER + V_FRONT_PORCH;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_TIME;
    localparam int V_TOTAL      = V_SYNC_END + V_BACK_PORCH + V_TOP_BORDER;

    localparam logic [COUNT_W-1:0] H_LAST     = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST     = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] ONE        = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] FETCH_INIT = COUNT_W'(FETCH_LEAD);
    localparam logic               H_ACTIVE   = (H_SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic               V_ACTIVE   = (V_SYNC_POL != 0) ? 1'b1 : 1'b0;

    if (H_TOTAL > (1 << COUNT_W)) begin : g_bad_h_total
        $error("H_TOTAL does not fit in COUNT_W bits");
    end
    if (V_TOTAL > (1 << COUNT_W)) begin : g_bad_v_total
        $error("V_TOTAL does not fit in COUNT_W bits");
    end
    if (FETCH_LEAD >= H_TOTAL || FETCH_LEAD < 0) begin : g_bad_fetch_lead
        $error("FETCH_LEAD must be in 0..H_TOTAL-1");
    end

    logic [COUNT_W-1:0] hpos_r, vpos_r, hpos_nxt_s, vpos_nxt_s;
    logic [COUNT_W-1:0] fetch_hpos_r, fetch_vpos_r, fetch_hpos_nxt_s, fetch_vpos_nxt_s;
    logic [FRAME_W-1:0] frame_count_r;
    logic               frame_wrap_s;
    logic               hsync_r, vsync_r, hsync_nxt_s, vsync_nxt_s;

    // Next display position, with line and frame wrap
    always_comb begin
        hpos_nxt_s   = hpos_r + ONE;
        vpos_nxt_s   = vpos_r;
        frame_wrap_s = 1'b0;
        if (hpos_r == H_LAST) begin
            hpos_nxt_s = '0;
            if (vpos_r == V_LAST) begin
                vpos_nxt_s   = '0;
                frame_wrap_s = 1'b1;
            end else begin
                vpos_nxt_s = vpos_r + ONE;
            end
        end else begin
            hpos_nxt_s = hpos_r + ONE;
        end
    end

    // Next fetch position, same wrap rules as the display counter
    always_comb begin
        fetch_hpos_nxt_s = fetch_hpos_r + ONE;
        fetch_vpos_nxt_s = fetch_vpos_r;
        if (fetch_hpos_r == H_LAST) begin
            fetch_hpos_nxt_s = '0;
            if (fetch_vpos_r == V_LAST) begin
                fetch_vpos_nxt_s = '0;
            end else begin
                fetch_vpos_nxt_s = fetch_vpos_r + ONE;
            end
        end else begin
            fetch_hpos_nxt_s = fetch_hpos_r + ONE;
        end
    end

    // Sync levels derived from the next display position so the registered
    // syncs line up with the registered position
    always_comb begin
        hsync_nxt_s = ~H_ACTIVE;
        vsync_nxt_s = ~V_ACTIVE;
        if ((int'(hpos_nxt_s) >= H_SYNC_START) && (int'(hpos_nxt_s) < H_SYNC_END)) begin
            hsync_nxt_s = H_ACTIVE;
        end else begin
            hsync_nxt_s = ~H_ACTIVE;
        end
        if ((int'(vpos_nxt_s) >= V_SYNC_START) && (int'(vpos_nxt_s) < V_SYNC_END)) begin
            vsync_nxt_s = V_ACTIVE;
        end else begin
            vsync_nxt_s = ~V_ACTIVE;
        end
    end

    // Display position register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hpos_r <= '0;
            vpos_r <= '0;
        end else if (i_ce) begin
            hpos_r <= hpos_nxt_s;
            vpos_r <= vpos_nxt_s;
        end
    end

    // Fetch position register, starts FETCH_LEAD ticks into the frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_hpos_r <= FETCH_INIT;
            fetch_vpos_r <= '0;
        end else if (i_ce) begin
            fetch_hpos_r <= fetch_hpos_nxt_s;
            fetch_vpos_r <= fetch_vpos_nxt_s;
        end
    end

    // Sync registers; reset drops any pulse in progress immediately
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hsync_r <= ~H_ACTIVE;
            vsync_r <= ~V_ACTIVE;
        end else if (i_ce) begin
            hsync_r <= hsync_nxt_s;
            vsync_r <= vsync_nxt_s;
        end
    end

    // Completed-frame counter, wraps modulo 2^FRAME_W
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_count_r <= '0;
        end else if (i_ce && frame_wrap_s) begin
            frame_count_r <= frame_count_r + FRAME_W'(1);
        end
    end

    assign o_hpos          = hpos_r;
    assign o_vpos          = vpos_r;
    assign o_fetch_hpos    = fetch_hpos_r;
    assign o_fetch_vpos    = fetch_vpos_r;
    assign o_frame_count   = frame_count_r;
    assign o_hsync         = hsync_r;
    assign o_vsync         = vsync_r;
    assign o_hblank        = (int'(hpos_r) >= H_VISIBLE);
    assign o_vblank        = (int'(vpos_r) >= V_VISIBLE);
    assign o_visible       = ~o_hblank & ~o_vblank;
    assign o_line_start    = i_ce & (hpos_r == '0);
    assign o_frame_start   = i_ce & (hpos_r == '0) & (vpos_r == '0);
    assign o_fetch_visible = (int'(fetch_hpos_r) < H_VISIBLE) & (int'(fetch_vpos_r) < V_VISIBLE);

endmodule
